// File: rtl/uart_tx_mapper.sv
// uart_tx_mapper: CPU-side memory-mapped UART transmitter.
// Bytes written by the CPU are queued in a small circular FIFO.
// They are then sent 8N1, LSB first, on a registered serial line.
module uart_tx_mapper #(
   parameter int CLKS_PER_BIT = 434,
   parameter int DEPTH        = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cpu_we,
   input  logic [7:0] cpu_data,
   input  logic       clear_overflow,
   output logic [7:0] status,
   output logic       tx_busy,
   output logic       fifo_full,
   output logic       fifo_empty,
   output logic       uart_tx
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = $clog2(DEPTH + 1);
   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  COUNT_FULL  = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0]  PTR_ONE     = PTR_W'(1);
   localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t            state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [2:0]        bitIdx_q, bitIdx_d;
   logic [7:0]        shift_q, shift_d;
   logic              txLine_q, txLine_d;
   logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
   logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              overflow_q, overflow_d;
   logic [7:0]        mem [DEPTH];

   logic isFull;
   logic pop;
   logic push;
   logic dropped;

   assign isFull  = (count_q == COUNT_FULL);
   // The serializer takes the head whenever it is idle and something is queued.
   // A write into a full FIFO still succeeds if that same cycle frees a slot.
   assign pop     = (state_q == IDLE) && (count_q != '0);
   assign push    = cpu_we && (!isFull || pop);
   assign dropped = cpu_we && isFull && !pop;

   // FIFO bookkeeping: pointer advance, occupancy and the sticky overflow flag.
   always_comb begin
      rdPtr_d    = rdPtr_q;
      wrPtr_d    = wrPtr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (push) begin
         wrPtr_d = wrPtr_q + PTR_ONE;
      end
      if (pop) begin
         rdPtr_d = rdPtr_q + PTR_ONE;
      end
      if (push && !pop) begin
         count_d = count_q + CNT_ONE;
      end else if (pop && !push) begin
         count_d = count_q - CNT_ONE;
      end
      if (dropped) begin
         overflow_d = 1'b1;
      end else if (clear_overflow) begin
         overflow_d = 1'b0;
      end
   end

   // Serializer sequencing.
   // Every state holds for CLKS_PER_BIT cycles, counted down in baud.
   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q;
      bitIdx_d = bitIdx_q;
      shift_d  = shift_q;
      unique case (state_q)
         IDLE: begin
            if (pop) begin
               shift_d = mem[rdPtr_q];
               baud_d  = BAUD_RELOAD;
               state_d = START;
            end
         end
         START: begin
            if (baud_q == '0) begin
               baud_d   = BAUD_RELOAD;
               bitIdx_d = 3'd0;
               state_d  = DATA;
            end else begin
               baud_d = baud_q - 1'b1;
            end
         end
         DATA: begin
            if (baud_q == '0) begin
               baud_d  = BAUD_RELOAD;
               shift_d = shift_q >> 1;
               if (bitIdx_q == 3'd7) begin
                  state_d = STOP;
               end else begin
                  bitIdx_d = bitIdx_q + 3'd1;
               end
            end else begin
               baud_d = baud_q - 1'b1;
            end
         end
         STOP: begin
            if (baud_q == '0) begin
               state_d = IDLE;
            end else begin
               baud_d = baud_q - 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // The line level is computed from the next state.
   // This lets the flop present the bit in the same cycle the state is entered.
   always_comb begin
      txLine_d = 1'b1;
      unique case (state_d)
         START:   txLine_d = 1'b0;
         DATA:    txLine_d = shift_d[0];
         default: txLine_d = 1'b1;
      endcase
   end

   // Control state registers.
   // Reset forces the line high at once and discards anything queued.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         baud_q     <= '0;
         bitIdx_q   <= 3'd0;
         shift_q    <= 8'h00;
         txLine_q   <= 1'b1;
         rdPtr_q    <= '0;
         wrPtr_q    <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         baud_q     <= baud_d;
         bitIdx_q   <= bitIdx_d;
         shift_q    <= shift_d;
         txLine_q   <= txLine_d;
         rdPtr_q    <= rdPtr_d;
         wrPtr_q    <= wrPtr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // FIFO storage needs no reset; the pointers and count say what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wrPtr_q] <= cpu_data;
      end
   end

   assign tx_busy    = (state_q != IDLE);
   assign fifo_full  = isFull;
   assign fifo_empty = (count_q == '0);
   assign uart_tx    = txLine_q;
   assign status     = {tx_busy, fifo_full, fifo_empty, overflow_q, 4'(count_q)};

endmodule

// File: doc/uart_tx_mapper.md
Name: uart_tx_mapper

Overview:
CPU-side UART transmitter that sends data in the opposite direction to the UART keyboard receive path. The 6502 writes bytes through a memory-mapped write strobe. Bytes are queued in a small FIFO and serialized 8N1, LSB first, on uart_tx. A status byte exposes busy, full, empty, overflow and FIFO count, so firmware can poll before writing. Runs on clk_sys (50 MHz).

Parameters:
CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); legal range >= 2
DEPTH, 4, FIFO depth in bytes; legal values 2, 4, 8

Ports:
clk  input  1  system clock (clk_sys); all logic on posedge
rst_n  input  1  asynchronous active-low reset
cpu_we  input  1  write strobe, one clk per byte, from decoded address/WE
cpu_data  input  8  byte to transmit, sampled when cpu_we=1
clear_overflow  input  1  one-cycle pulse, clears the sticky overflow flag
status  output  8  {busy, full, empty, overflow, count[3:0]}
tx_busy  output  1  serializer not in IDLE
fifo_full  output  1  count == DEPTH
fifo_empty  output  1  count == 0
uart_tx  output  1  serial line, idle high

Behaviour:
- Reset (async, rst_n=0): uart_tx=1, tx_busy=0, fifo_empty=1, fifo_full=0, overflow=0, count=0, status=8'h20. FIFO pointers cleared. Asserting reset mid-frame forces uart_tx high immediately and discards the FIFO contents.
- FIFO:
  - Circular buffer with rd_ptr and wr_ptr of log2(DEPTH) bits and a count register 0..DEPTH.
  - Push on cpu_we when not full.
  - Pop when the serializer is in IDLE and the FIFO is not empty.
  - Simultaneous push and pop: both happen and count is unchanged. This holds even when full; the write is accepted because a slot frees in the same cycle.
  - cpu_we while full with no pop: byte dropped, overflow set (sticky).
  - clear_overflow clears overflow. If an overflow event occurs in the same cycle, set wins.
- Serializer FSM, states IDLE, START, DATA, STOP:
  - IDLE: uart_tx=1. If not empty, pop the head into an 8-bit shift register, load baud_cnt=CLKS_PER_BIT-1 and go to START.
  - START: uart_tx=0. When baud_cnt reaches 0, reload it, set bit_idx=0 and go to DATA.
  - DATA: uart_tx=shift[0]. When baud_cnt reaches 0, reload it and shift right. After bit_idx 7, go to STOP; otherwise increment bit_idx.
  - STOP: uart_tx=1. When baud_cnt reaches 0, go to IDLE.
  - Each bit lasts exactly CLKS_PER_BIT clk cycles, and a frame is 10*CLKS_PER_BIT cycles.
  - Back-to-back frames: leaving STOP and popping in IDLE cost exactly 1 extra high cycle between frames.
- uart_tx is registered (driven from a flop) so it is glitch-free.
- Latency, write at cycle N into an empty FIFO with the FSM in IDLE:
  - count=1 visible at N+1.
  - Pop at N+1; FSM in START from N+2.
  - uart_tx falls at N+2.
- tx_busy=1 in START, DATA and STOP.
- Status encoding: status[7]=tx_busy, [6]=fifo_full, [5]=fifo_empty, [4]=overflow, [3:0]=count. All fields are registered state.
- Writes arriving while a frame is in flight only affect the FIFO and never disturb the current frame.

Test Plan:
- Reset values: hold rst_n=0, release -> uart_tx=1, status=8'h20, tx_busy=0 for 100 cycles with no writes.
- Single byte, CLKS_PER_BIT=4: write 8'h55 at cycle N -> uart_tx low from N+2. Bit sequence 0,1,0,1,0,1,0,1,0,1, 4 cycles each. Line high from N+42; tx_busy=0 at N+42.
- Back-to-back, CLKS_PER_BIT=4: write 8'hA3 then 8'h0F on consecutive cycles -> two frames decode as A3 then 0F. Exactly 5 high cycles (4 stop + 1 idle) between frames. status count goes 1, then 1 (push/pop overlap), then 0.
- Overflow, DEPTH=4: during an active frame write 6 bytes 01..06 -> FIFO holds 02..05 (01 already popped), 06 dropped, status=8'hD4 (busy, full, overflow, count=4). Transmitted order is 01..05. A clear_overflow pulse clears bit 4.
- Full with simultaneous pop: fill the FIFO and time a cpu_we to coincide with the IDLE pop -> byte accepted, count stays DEPTH, overflow stays 0.
- Reset mid-frame: assert rst_n=0 during DATA bit 3 -> uart_tx=1 immediately and status=8'h20. After release no residual bytes are sent.
